// File: rtl/seq6_pkg.sv
// Shared definitions for the 6-state sequence monitor: code constants,
// FSM state encoding and default counter widths.
package seq6_pkg;

   // Legal counter codes, named by their binary value.
   localparam logic [2:0] S0 = 3'b000;
   localparam logic [2:0] S1 = 3'b001;
   localparam logic [2:0] S3 = 3'b011;
   localparam logic [2:0] S4 = 3'b100;
   localparam logic [2:0] S6 = 3'b110;
   localparam logic [2:0] S7 = 3'b111;

   // Index of the last code in a lap (100).
   localparam logic [2:0] IDX_LAST = 3'd5;

   localparam int unsigned DEF_ERR_W = 4;
   localparam int unsigned DEF_LAP_W = 8;

   typedef enum logic [1:0] {
      StUnlocked,
      StLocked,
      StFault
   } mon_state_e;

endpackage

// File: rtl/seq6_decode.sv
// Combinational decoder for one counter code: position index, legality
// and expected successor in the 000-011-001-111-110-100 cycle.
module seq6_decode
   import seq6_pkg::*;
(
   input  logic [2:0] code,
   output logic [2:0] idx,
   output logic       legal,
   output logic [2:0] succ
);

   // Map each code to its position and successor; 010/101 are illegal.
   always_comb begin
      idx   = 3'd0;
      legal = 1'b1;
      succ  = S0;
      unique case (code)
         S0: begin idx = 3'd0; succ = S3; end
         S3: begin idx = 3'd1; succ = S1; end
         S1: begin idx = 3'd2; succ = S7; end
         S7: begin idx = 3'd3; succ = S6; end
         S6: begin idx = 3'd4; succ = S4; end
         S4: begin idx = 3'd5; succ = S0; end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seq6_monitor.sv
// Sequence monitor for the 6-state counter. Locks on code 000, tracks the
// position index, pulses wrap per completed lap and err per fault.
// Optional macro SEQ6_MON_RESYNC_EN: when defined, a sampled 000 in FAULT
// re-locks the monitor; otherwise FAULT is held until reset.
module seq6_monitor
   import seq6_pkg::*;
#(
   parameter int unsigned ERR_W = DEF_ERR_W,
   parameter int unsigned LAP_W = DEF_LAP_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       count_in,
   output logic [2:0]       idx,
   output logic             locked,
   output logic             wrap,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic [LAP_W-1:0] lap_cnt
);

   mon_state_e       state_q, state_d;
   logic [2:0]       prev_q, prev_d;
   logic [2:0]       idx_q, idx_d;
   logic             wrap_q, wrap_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;

   logic [2:0] in_idx;
   logic       in_legal;
   logic [2:0] unused_in_succ;
   logic [2:0] prev_idx;
   logic       prev_legal;
   logic [2:0] prev_succ;

   seq6_decode u_dec_in (
      .code  (count_in),
      .idx   (in_idx),
      .legal (in_legal),
      .succ  (unused_in_succ)
   );

   seq6_decode u_dec_prev (
      .code  (prev_q),
      .idx   (prev_idx),
      .legal (prev_legal),
      .succ  (prev_succ)
   );

   // Next-state: lock/accept/stall/fault decisions on each qualified sample.
   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      idx_d     = idx_q;
      wrap_d    = 1'b0;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      lap_cnt_d = lap_cnt_q;
      if (en) begin
         unique case (state_q)
            StUnlocked: begin
               if (count_in == S0) begin
                  state_d = StLocked;
                  prev_d  = S0;
                  idx_d   = 3'd0;
               end else if (!in_legal) begin
                  err_d = 1'b1;
               end
            end
            StLocked: begin
               if (in_legal && prev_legal && (count_in == prev_succ)) begin
                  prev_d = count_in;
                  idx_d  = in_idx;
                  if ((prev_idx == IDX_LAST) && (in_idx == 3'd0)) begin
                     wrap_d    = 1'b1;
                     lap_cnt_d = lap_cnt_q + LAP_W'(1);
                  end
               end else if (count_in != prev_q) begin
                  // Repeating prev is a legal stall; anything else faults.
                  err_d   = 1'b1;
                  state_d = StFault;
               end
            end
            StFault: begin
`ifdef SEQ6_MON_RESYNC_EN
               if (count_in == S0) begin
                  state_d = StLocked;
                  prev_d  = S0;
                  idx_d   = 3'd0;
               end
`endif
            end
            default: state_d = StUnlocked;
         endcase
      end
      if (err_d && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   // State register with asynchronous clear of every output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StUnlocked;
         prev_q    <= S0;
         idx_q     <= 3'd0;
         wrap_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         lap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         idx_q     <= idx_d;
         wrap_q    <= wrap_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         lap_cnt_q <= lap_cnt_d;
      end
   end

   assign idx     = idx_q;
   assign locked  = (state_q == StLocked);
   assign wrap    = wrap_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign lap_cnt = lap_cnt_q;

endmodule

// File: tb/tb_seq6_monitor.sv
// Self-checking bench for seq6_monitor: a default-width instance and a
// narrow instance (ERR_W=2, LAP_W=2) share stimulus; a behavioural model
// pushes expected outputs to a scoreboard checked after each edge.
module tb_seq6_monitor;

   typedef struct packed {
      logic [2:0] idx;
      logic       locked;
      logic       wrap;
      logic       err;
      logic [3:0] ec;
      logic [7:0] lc;
      logic [1:0] ec_s;
      logic [1:0] lc_s;
   } exp_t;

   localparam int MU = 0;
   localparam int ML = 1;
   localparam int MF = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       en = 1'b0;
   logic [2:0] count_in = 3'b000;

   logic [2:0] idx, idx_s;
   logic       locked, locked_s, wrap, wrap_s, err, err_s;
   logic [3:0] err_cnt;
   logic [7:0] lap_cnt;
   logic [1:0] err_cnt_s, lap_cnt_s;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];
   exp_t sb_exp, sb_act;

   logic [2:0] seq_tbl [6] = '{3'b000, 3'b011, 3'b001, 3'b111, 3'b110, 3'b100};

   int         m_state;
   logic [2:0] m_prev;
   int         m_idx;
   int         m_errs;
   int         m_laps;
   logic       m_wrap, m_err;

   seq6_monitor dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .count_in (count_in),
      .idx      (idx),
      .locked   (locked),
      .wrap     (wrap),
      .err      (err),
      .err_cnt  (err_cnt),
      .lap_cnt  (lap_cnt)
   );

   seq6_monitor #(.ERR_W(2), .LAP_W(2)) dut_s (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .count_in (count_in),
      .idx      (idx_s),
      .locked   (locked_s),
      .wrap     (wrap_s),
      .err      (err_s),
      .err_cnt  (err_cnt_s),
      .lap_cnt  (lap_cnt_s)
   );

   always #5 clk = ~clk;

   function automatic int code_index(input logic [2:0] c);
      for (int i = 0; i < 6; i++) begin
         if (seq_tbl[i] == c) return i;
      end
      return -1;
   endfunction

   task automatic model_clear();
      m_state = MU;
      m_prev  = 3'b000;
      m_idx   = 0;
      m_errs  = 0;
      m_laps  = 0;
      m_wrap  = 1'b0;
      m_err   = 1'b0;
      sb.delete();
   endtask

   // Drive one sample, advance the model, queue the expectation, then step.
   task automatic drive(input logic e, input logic [2:0] c);
      int   ci;
      int   pi;
      exp_t x;
      @(negedge clk);
      en       = e;
      count_in = c;
      m_wrap   = 1'b0;
      m_err    = 1'b0;
      if (e) begin
         ci = code_index(c);
         pi = code_index(m_prev);
         case (m_state)
            MU: begin
               if (c == 3'b000) begin
                  m_state = ML; m_prev = c; m_idx = 0;
               end else if (ci < 0) begin
                  m_err = 1'b1;
               end
            end
            ML: begin
               if (ci >= 0 && ci == (pi + 1) % 6) begin
                  if (ci == 0) begin
                     m_wrap = 1'b1;
                     m_laps++;
                  end
                  m_prev = c;
                  m_idx  = ci;
               end else if (c != m_prev) begin
                  m_err   = 1'b1;
                  m_state = MF;
               end
            end
            default: begin
`ifdef SEQ6_MON_RESYNC_EN
               if (c == 3'b000) begin
                  m_state = ML; m_prev = c; m_idx = 0;
               end
`endif
            end
         endcase
      end
      if (m_err) m_errs++;
      x.idx    = 3'(m_idx);
      x.locked = (m_state == ML);
      x.wrap   = m_wrap;
      x.err    = m_err;
      x.ec     = (m_errs > 15) ? 4'd15 : 4'(m_errs);
      x.ec_s   = (m_errs > 3) ? 2'd3 : 2'(m_errs);
      x.lc     = 8'(m_laps % 256);
      x.lc_s   = 2'(m_laps % 4);
      sb.push_back(x);
      @(posedge clk);
      #2;
   endtask

   // Scoreboard: compare the queued expectation with both DUTs after each edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         sb_exp        = sb.pop_front();
         sb_act.idx    = idx;
         sb_act.locked = locked;
         sb_act.wrap   = wrap;
         sb_act.err    = err;
         sb_act.ec     = err_cnt;
         sb_act.lc     = lap_cnt;
         sb_act.ec_s   = err_cnt_s;
         sb_act.lc_s   = lap_cnt_s;
         checks++;
         if (sb_act !== sb_exp || idx_s !== idx || locked_s !== locked ||
             wrap_s !== wrap || err_s !== err) begin
            errors++;
            $display("FAIL scoreboard t=%0t got idx=%0d lk=%b wr=%b er=%b ec=%0d lc=%0d ecs=%0d lcs=%0d (narrow idx=%0d lk=%b wr=%b er=%b) expected idx=%0d lk=%b wr=%b er=%b ec=%0d lc=%0d ecs=%0d lcs=%0d",
                     $time, idx, locked, wrap, err, err_cnt, lap_cnt, err_cnt_s, lap_cnt_s,
                     idx_s, locked_s, wrap_s, err_s, sb_exp.idx, sb_exp.locked, sb_exp.wrap,
                     sb_exp.err, sb_exp.ec, sb_exp.lc, sb_exp.ec_s, sb_exp.lc_s);
         end
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b0;
      model_clear();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({idx, locked, wrap, err, err_cnt, lap_cnt, idx_s, err_cnt_s, lap_cnt_s} !== '0) begin
         errors++;
         $display("FAIL reset_state got idx=%0d lk=%b wr=%b er=%b ec=%0d lc=%0d expected all zero",
                  idx, locked, wrap, err, err_cnt, lap_cnt);
      end
      apply_reset();
   endtask

   task automatic test_lap();
      int wraps = 0;
      apply_reset();
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, seq_tbl[i % 6]);
         if (wrap) wraps++;
         if (i == 0) begin
            checks++;
            if (locked !== 1'b1) begin
               errors++;
               $display("FAIL lap_first_lock got %b expected 1", locked);
            end
         end
      end
      checks++;
      if (wraps != 2 || lap_cnt !== 8'd2 || err_cnt !== 4'd0) begin
         errors++;
         $display("FAIL lap_totals got wraps=%0d lc=%0d ec=%0d expected wraps=2 lc=2 ec=0",
                  wraps, lap_cnt, err_cnt);
      end
   endtask

   task automatic test_illegal();
      apply_reset();
      drive(1'b1, 3'b000);
      drive(1'b1, 3'b011);
      drive(1'b1, 3'b010);
      checks++;
      if (err !== 1'b1 || err_cnt !== 4'd1 || locked !== 1'b0 || idx !== 3'd1) begin
         errors++;
         $display("FAIL illegal_code got er=%b ec=%0d lk=%b idx=%0d expected er=1 ec=1 lk=0 idx=1",
                  err, err_cnt, locked, idx);
      end
      drive(1'b1, 3'b001);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL illegal_single_pulse got er=%b expected 0", err);
      end
   endtask

   task automatic test_stall();
      logic ens [3] = '{1'b0, 1'b1, 1'b0};
      apply_reset();
      for (int i = 0; i < 4; i++) drive(1'b1, seq_tbl[i]);
      for (int i = 0; i < 3; i++) begin
         drive(ens[i], 3'b111);
         checks++;
         if (err !== 1'b0 || idx !== 3'd3 || locked !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold step=%0d got er=%b idx=%0d lk=%b expected er=0 idx=3 lk=1",
                     i, err, idx, locked);
         end
      end
      drive(1'b1, 3'b110);
      checks++;
      if (idx !== 3'd4 || err !== 1'b0) begin
         errors++;
         $display("FAIL stall_resume got idx=%0d er=%b expected idx=4 er=0", idx, err);
      end
   endtask

   task automatic test_out_of_order();
      apply_reset();
      drive(1'b1, 3'b000);
      drive(1'b1, 3'b011);
      drive(1'b1, 3'b001);
      drive(1'b1, 3'b110);
      checks++;
      if (err !== 1'b1 || err_cnt !== 4'd1 || locked !== 1'b0) begin
         errors++;
         $display("FAIL ooo_fault got er=%b ec=%0d lk=%b expected er=1 ec=1 lk=0",
                  err, err_cnt, locked);
      end
      drive(1'b1, 3'b000);
      checks++;
`ifdef SEQ6_MON_RESYNC_EN
      if (locked !== 1'b1 || idx !== 3'd0 || err_cnt !== 4'd1) begin
         errors++;
         $display("FAIL ooo_resync got lk=%b idx=%0d ec=%0d expected lk=1 idx=0 ec=1",
                  locked, idx, err_cnt);
      end
`else
      if (locked !== 1'b0 || err_cnt !== 4'd1) begin
         errors++;
         $display("FAIL ooo_sticky got lk=%b ec=%0d expected lk=0 ec=1", locked, err_cnt);
      end
`endif
      // Further faults: frozen in sticky FAULT, counted again after resync.
      drive(1'b1, 3'b101);
      drive(1'b1, 3'b000);
      drive(1'b1, 3'b011);
   endtask

   task automatic test_saturate();
      apply_reset();
      for (int i = 0; i < 18; i++) drive(1'b1, (i % 2 == 0) ? 3'b010 : 3'b101);
      checks++;
      if (err_cnt_s !== 2'd3 || err_cnt !== 4'd15) begin
         errors++;
         $display("FAIL saturate got narrow=%0d wide=%0d expected narrow=3 wide=15",
                  err_cnt_s, err_cnt);
      end
   endtask

   task automatic test_lap_wrap();
      apply_reset();
      for (int i = 0; i < 31; i++) drive(1'b1, seq_tbl[i % 6]);
      checks++;
      if (lap_cnt_s !== 2'd1 || lap_cnt !== 8'd5) begin
         errors++;
         $display("FAIL lap_wrap got narrow=%0d wide=%0d expected narrow=1 wide=5",
                  lap_cnt_s, lap_cnt);
      end
   endtask

   task automatic test_reset_mid_lap();
      apply_reset();
      drive(1'b1, 3'b010);
      drive(1'b1, 3'b000);
      drive(1'b1, 3'b011);
      drive(1'b1, 3'b001);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({idx, locked, wrap, err, err_cnt, lap_cnt, idx_s, err_cnt_s} !== '0) begin
         errors++;
         $display("FAIL reset_async got idx=%0d lk=%b wr=%b er=%b ec=%0d lc=%0d expected all zero",
                  idx, locked, wrap, err, err_cnt, lap_cnt);
      end
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 3'b011);
      drive(1'b1, 3'b000);
      checks++;
      if (locked !== 1'b1 || idx !== 3'd0) begin
         errors++;
         $display("FAIL reset_relock got lk=%b idx=%0d expected lk=1 idx=0", locked, idx);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_lap();
      test_illegal();
      test_stall();
      test_out_of_order();
      test_saturate();
      test_lap_wrap();
      test_reset_mid_lap();
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq6_monitor.md
# seq6_monitor

Downstream checker for the 6-state sequence counter (000→011→001→111→110→100→000). Samples the counter's `count` bus, locks onto the sequence at code 000, tracks the position index, pulses on each completed lap, and flags and counts any illegal code or out-of-order transition. Sits directly on the counter output for on-chip self-check and bench scoreboarding.

## Interface
- `ERR_W`, 4: width of the saturating error counter.
- `LAP_W`, 8: width of the wrapping lap counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `en`  in  1  sample qualifier; `count_in` is evaluated only on edges where `en`=1.
- `count_in`  in  3  counter code under test.
- `idx`  out  3  position of the last accepted code, 0..5.
- `locked`  out  1  high while the FSM is in LOCKED.
- `wrap`  out  1  one-cycle pulse on an accepted 100→000 transition.
- `err`  out  1  one-cycle pulse on a detected fault.
- `err_cnt`  out  ERR_W  fault count; saturates at all-ones.
- `lap_cnt`  out  LAP_W  completed laps, modulo 2^LAP_W.

## Operation
- Code-to-index mapping: 000=0, 011=1, 001=2, 111=3, 110=4, 100=5. Codes 010 and 101 are illegal.
- Successor rule: succ(000)=011, succ(011)=001, succ(001)=111, succ(111)=110, succ(110)=100, succ(100)=000.
- Internal register `prev` (3 bits) holds the last accepted code. Reset value is 000.
- FSM states: UNLOCKED, LOCKED, FAULT. Reset state is UNLOCKED.
- UNLOCKED, `en`=1:
  - code 000 → LOCKED; `prev`=000; `idx`=0.
  - Any other legal code → stay; no pulses.
  - Illegal code → `err` pulse and `err_cnt`+1; stay UNLOCKED.
- LOCKED, `en`=1:
  - code == succ(`prev`) → accept; `prev`=code; `idx`=index(code).
  - If that accepted transition is 100→000 → `wrap` pulse and `lap_cnt`+1.
  - code == `prev` → stall; legal, no change, no pulse.
  - Anything else (including illegal codes) → `err` pulse, `err_cnt`+1, go to FAULT. `idx` and `prev` hold.
- FAULT: no `err` pulses; `err_cnt` is frozen. Exit behaviour is set under Configuration.
- `en`=0: all state holds; `wrap` and `err` are 0 on that cycle.
- `err_cnt` saturates at 2^ERR_W−1. `lap_cnt` wraps to 0 after all-ones.

## Timing
- All outputs are registered. Latency is one edge from `count_in` being sampled to the outputs updating.
- A counter driven by the same `clk` is checked one edge behind its update.
- `wrap` and `err` are exactly one cycle wide. They are mutually exclusive on a given cycle.
- Reset values: `idx`=0, `locked`=0, `wrap`=0, `err`=0, `err_cnt`=0, `lap_cnt`=0.
- Reset asserted mid-lap or in FAULT: all outputs clear asynchronously and the FSM returns to UNLOCKED. After release, the first sampled 000 re-locks.

## Configuration
- Macro `SEQ6_MON_RESYNC_EN`.
- Defined: in FAULT, a sampled code 000 (with `en`=1) returns the FSM to LOCKED with `prev`=000 and `idx`=0. `err_cnt` is retained, so further faults count again.
- Undefined: FAULT is sticky until `reset`.

## Structure
- Package `seq6_pkg` contains:
  - 3-bit code constants S0, S1, S3, S4, S6, S7.
  - FSM state enum (UNLOCKED/LOCKED/FAULT).
  - Default ERR_W/LAP_W constants.
- Sub-module `seq6_decode` (combinational) takes a code and produces `idx`, `legal`, and `succ`. The monitor instantiates it once on `count_in` and once on `prev`.

## Test plan
- Reset, then drive the legal sequence from 000 for 13 edges → `locked`=1 after the first edge; `idx` steps 0,1,2,3,4,5,0…; `wrap` pulses twice; `lap_cnt`=2; `err_cnt`=0.
- Locked at 011, then inject 010 → one `err` pulse; `err_cnt`=1; `locked`=0; `idx` holds 1.
- Locked at 111, then drive 111 for 3 edges with `en` toggling → no `err`; `idx`=3 throughout; next 110 is accepted with `idx`=4.
- Out-of-order 001→110 while locked, followed by 000:
  - With `SEQ6_MON_RESYNC_EN`: `err_cnt`=1, then `locked`=1 with `idx`=0.
  - Without it: `locked` stays 0 until `reset`.
- ERR_W=2 with repeated fault/resync cycles → `err_cnt` saturates at 3. Assert `reset` mid-lap → all outputs are 0 before the next edge.
